lvds_pixel_feeder: RTL and testbench

//   Upstream stage of the LVDS panel output. Buffers RGB888 pixels from the frame-buffer reader
//   in a small FIFO and generates panel raster timing (hsync/vsync/dataenable).

---
 rtl/lvds_pixel_feeder_if.sv | 12 +
 rtl/lvds_pixel_feeder.sv | 170 +++++++++++++++++
 tb/tb_lvds_pixel_feeder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_pixel_feeder_if.sv
// Upstream pixel stream from the frame-buffer reader: RGB888 plus start-of-frame marker.
// Latency: none, this only bundles wires.
// Backpressure: valid/ready; a pixel moves on a cycle where both are high.
interface lvds_pixel_feeder_if;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;

    modport master (output s_valid, output s_data, output s_sof, input s_ready);
    modport slave  (input s_valid, input s_data, input s_sof, output s_ready);
endinterface

// File: rtl/lvds_pixel_feeder.sv
// Pixel FIFO plus raster timing generator feeding the LVDS serializer, one pixel per clock.
// Latency: every output is registered one clock after the counter position it describes.
// Backpressure: s_ready = !full (and low in reset); the raster never stalls, so an empty FIFO is an underflow.
module lvds_pixel_feeder #(
    parameter int          HACTIVE         = 1280,
    parameter int          HTOTAL          = 1440,
    parameter int          VACTIVE         = 800,
    parameter int          VTOTAL          = 823,
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
    input  logic                i_clk_in,
    input  logic                i_rst,
    lvds_pixel_feeder_if.slave  s_if,
    output logic [7:0]          o_red,
    output logic [7:0]          o_green,
    output logic [7:0]          o_blue,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic                o_dataenable,
    output logic                o_frame_start,
    output logic                o_underflow,
    output logic                o_locked
);
    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_WAIT_SOF, ST_RUN, ST_RESYNC} state_t;

    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [24:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    state_t        w_next_state;
    logic [23:0]   r_rgb;
    logic          r_hsync, r_vsync, r_de, r_fs, r_uf, r_locked;

    logic        w_h_act, w_v_act, w_active, w_origin;
    logic        w_empty, w_full, w_wr, w_pop, w_head_sof, w_fs, w_uf_set;
    logic [24:0] w_head;
    logic [23:0] w_rgb;

    assign w_h_act    = r_hcount < HW'(HACTIVE);
    assign w_v_act    = r_vcount < VW'(VACTIVE);
    assign w_active   = w_h_act && w_v_act;
    assign w_origin   = (r_hcount == '0) && (r_vcount == '0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign s_if.s_ready = !i_rst && !w_full;
    assign w_wr       = s_if.s_valid && s_if.s_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_sof = w_head[24];

    // Free-running raster counters, independent of lock state
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == HW'(HTOTAL - 1)) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == VW'(VTOTAL - 1)) ? '0 : r_vcount + 1'b1;
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge i_clk_in) begin
        if (w_wr) r_mem[r_wr_ptr] <= {s_if.s_sof, s_if.s_data};
    end

    // FIFO pointers and occupancy; a write while empty only becomes readable next cycle
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
        end
    end

    // State register
    always_ff @(posedge i_clk_in) begin
        if (i_rst) r_state <= ST_WAIT_SOF;
        else       r_state <= w_next_state;
    end

    // Next state: RUN drops out on an empty or misaligned active pixel; otherwise wait for sof at origin
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_active && (w_empty || (w_head_sof != w_origin))) w_next_state = ST_RESYNC;
            end
            default: begin
                if (!w_empty && w_head_sof && w_origin) w_next_state = ST_RUN;
            end
        endcase
    end

    // Per-state pop decision and pixel selection
    always_comb begin
        w_pop    = 1'b0;
        w_rgb    = UNDERFLOW_COLOR;
        w_fs     = 1'b0;
        w_uf_set = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!w_active) begin
                    w_rgb = '0;
                end else if (w_empty) begin
                    w_uf_set = 1'b1;
                end else if (w_head_sof == w_origin) begin
                    w_pop = 1'b1;
                    w_rgb = w_head[23:0];
                    w_fs  = w_origin;
                end
            end
            default: begin
                if (!w_empty) begin
                    if (!w_head_sof) begin
                        w_pop = 1'b1;
                    end else if (w_origin) begin
                        w_pop = 1'b1;
                        w_rgb = w_head[23:0];
                        w_fs  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Output registers, one clock behind the counters; underflow is sticky until reset
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_rgb    <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_de     <= 1'b0;
            r_fs     <= 1'b0;
            r_uf     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_rgb    <= w_rgb;
            r_hsync  <= w_h_act;
            r_vsync  <= w_v_act;
            r_de     <= w_active;
            r_fs     <= w_fs;
            r_uf     <= r_uf | w_uf_set;
            r_locked <= (w_next_state == ST_RUN);
        end
    end

    assign o_red         = r_rgb[23:16];
    assign o_green       = r_rgb[15:8];
    assign o_blue        = r_rgb[7:0];
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_dataenable  = r_de;
    assign o_frame_start = r_fs;
    assign o_underflow   = r_uf;
    assign o_locked      = r_locked;
endmodule

// File: tb/tb_lvds_pixel_feeder.sv
// Bench for lvds_pixel_feeder: directed scenarios with a queue-based reference model.
// The model advances on each rising edge; outputs are compared on each falling edge.
// Stimulus is driven on the falling edge; s_ready is checked 1 time unit later.
module tb_lvds_pixel_feeder;
    localparam int          HA    = 4;
    localparam int          HT    = 6;
    localparam int          VA    = 2;
    localparam int          VT    = 3;
    localparam int          DEPTH = 4;
    localparam logic [23:0] UCOL  = 24'h000000;

    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, dataenable, frame_start, underflow, locked;

    lvds_pixel_feeder_if u_if ();
    assign u_if.s_valid = s_valid;
    assign u_if.s_data  = s_data;
    assign u_if.s_sof   = s_sof;

    lvds_pixel_feeder #(
        .HACTIVE(HA), .HTOTAL(HT), .VACTIVE(VA), .VTOTAL(VT),
        .FIFO_DEPTH(DEPTH), .UNDERFLOW_COLOR(UCOL)
    ) u_dut (
        .i_clk_in(clk), .i_rst(rst), .s_if(u_if),
        .o_red(red), .o_green(green), .o_blue(blue),
        .o_hsync(hsync), .o_vsync(vsync), .o_dataenable(dataenable),
        .o_frame_start(frame_start), .o_underflow(underflow), .o_locked(locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t        m_q[$];
    int          m_h = 0, m_v = 0;
    bit          m_locked = 0, m_uf = 0;
    logic [23:0] e_rgb = '0;
    bit          e_hs = 0, e_vs = 0, e_de = 0, e_fs = 0, e_uf = 0, e_lk = 0;

    task automatic model_step();
        bit          push, have, act, org, pop, fs;
        ent_t        head;
        logic [23:0] rgb;
        if (rst) begin
            m_q.delete();
            m_h = 0; m_v = 0; m_locked = 0; m_uf = 0;
            e_rgb = '0; e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_uf = 0; e_lk = 0;
            return;
        end
        push = s_valid && (m_q.size() < DEPTH);
        have = (m_q.size() > 0);
        head = have ? m_q[0] : '0;
        act  = (m_h < HA) && (m_v < VA);
        org  = (m_h == 0) && (m_v == 0);
        rgb  = UCOL; pop = 0; fs = 0;
        if (!m_locked) begin
            if (have && !head.sof) pop = 1;
            else if (have && org) begin pop = 1; rgb = head.rgb; fs = 1; m_locked = 1; end
        end else if (!act) begin
            rgb = '0;
        end else if (!have) begin
            m_uf = 1; m_locked = 0;
        end else if (org && head.sof) begin
            pop = 1; rgb = head.rgb; fs = 1;
        end else if (!org && !head.sof) begin
            pop = 1; rgb = head.rgb;
        end else begin
            m_locked = 0;
        end
        e_rgb = rgb; e_hs = (m_h < HA); e_vs = (m_v < VA); e_de = act;
        e_fs = fs; e_uf = m_uf; e_lk = m_locked;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({s_sof, s_data});
        m_h++;
        if (m_h == HT) begin
            m_h = 0; m_v++;
            if (m_v == VT) m_v = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare registered outputs against the model every cycle
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("rgb", {red, green, blue}, e_rgb);
            chk("hsync", hsync, e_hs);
            chk("vsync", vsync, e_vs);
            chk("dataenable", dataenable, e_de);
            chk("frame_start", frame_start, e_fs);
            chk("underflow", underflow, e_uf);
            chk("locked", locked, e_lk);
        end
    end

    // ---------------- stimulus generator ----------------
    logic [23:0] g_val = '0;
    int          g_idx = 0;
    int          j_left = 0;
    bit          last_acc = 0;

    task automatic gen_reset(input logic [23:0] first, input int junk);
        g_val = first; g_idx = 0; j_left = junk; last_acc = 0;
    endtask

    task automatic cyc(input bit r, input bit v);
        @(negedge clk);
        if (last_acc) begin
            if (j_left > 0) j_left--;
            else begin g_val++; g_idx = (g_idx == 7) ? 0 : g_idx + 1; end
        end
        rst = r;
        s_valid = v;
        if (j_left > 0) begin s_data = 24'hAA0000 | 24'(j_left); s_sof = 1'b0; end
        else begin s_data = g_val; s_sof = (g_idx == 0); end
        last_acc = v && !r && (m_q.size() < DEPTH);
        #1;
        chk("s_ready", u_if.s_ready, 32'(!r && (m_q.size() < DEPTH)));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int          n_acc;
        int          fs_cyc[$];
        logic [23:0] fs_rgb[$];
        logic [23:0] pix[$];
        bit          seen, hit;
        logic [23:0] v;

        chk_en = 1'b1;
        gen_reset(24'h000001, 0);

        // 1: reset held with valid high
        repeat (3) cyc(1, 1);
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_flags", {hsync, vsync, dataenable, frame_start, underflow, locked}, 0);
        chk("rst_ready", u_if.s_ready, 0);
        cyc(0, 1);
        chk("ready_after_rst", u_if.s_ready, 1);
        chk("hsync_before_first_edge", hsync, 0);
        cyc(0, 1);
        chk("hsync_latency", hsync, 1);

        // 2: continuous stream, 8-pixel frames with sof on the first
        for (int c = 0; c < 80; c++) begin
            cyc(0, 1);
            if (frame_start) begin fs_cyc.push_back(c); fs_rgb.push_back({red, green, blue}); end
            if (dataenable && locked) pix.push_back({red, green, blue});
        end
        chk("frame_starts_seen", 32'(fs_cyc.size() >= 2), 1);
        if (fs_cyc.size() >= 2) begin
            chk("first_frame_rgb", fs_rgb[0], 24'h000001);
            chk("frame_period", fs_cyc[1] - fs_cyc[0], 18);
        end
        chk("frame0_pixel_count", 32'(pix.size() >= 8), 1);
        for (int i = 0; i < 8 && i < pix.size(); i++) chk("frame0_pixel", pix[i], i + 1);
        chk("locked_in_run", locked, 1);
        chk("no_underflow_in_run", underflow, 0);

        // 3: upstream stalls mid row 1, underflow then relock
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            cyc(0, 1);
            hit = (m_v == 1) && (m_h == 1);
        end
        chk("wait_row1_timeout", hit, 1);
        seen = 0; v = 24'hFFFFFF;
        for (int c = 0; c < 20; c++) begin
            cyc(0, 0);
            if (underflow && !locked && !seen) begin seen = 1; v = {red, green, blue}; end
        end
        chk("underflow_unlocked", seen, 1);
        chk("underflow_rgb", v, UCOL);
        hit = 0;
        for (int c = 0; c < 60; c++) begin
            cyc(0, 1);
            if (frame_start && underflow) hit = 1;
        end
        chk("relock_after_underflow", hit, 1);
        chk("underflow_sticky", underflow, 1);
        chk("relocked", locked, 1);

        // 4: junk pixels ahead of a sof frame
        gen_reset(24'h000100, 3);
        repeat (2) cyc(1, 0);
        seen = 0; v = '0;
        for (int c = 0; c < 40; c++) begin
            cyc(0, 1);
            if (frame_start && !seen) begin seen = 1; v = {red, green, blue}; end
        end
        chk("sof_after_junk_seen", seen, 1);
        chk("sof_after_junk_rgb", v, 24'h000100);

        // 5: FIFO fills while waiting for origin
        gen_reset(24'h010000, 0);
        repeat (2) cyc(1, 0);
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(0, 1);
            n_acc += (s_valid && u_if.s_ready) ? 1 : 0;
        end
        chk("accepted_until_full", n_acc, 4);
        chk("ready_low_when_full", u_if.s_ready, 0);
        repeat (30) cyc(0, 1);

        // 6: reset at hcount=2, vcount=1 while running
        hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            cyc(0, 1);
            hit = m_locked && (m_v == 1) && (m_h == 1);
        end
        chk("wait_run_timeout", hit, 1);
        cyc(1, 1);
        cyc(1, 0);
        chk("midframe_rst_rgb", {red, green, blue}, 0);
        chk("midframe_rst_flags", {hsync, vsync, dataenable, frame_start, underflow, locked}, 0);
        chk("midframe_rst_ready", u_if.s_ready, 0);
        gen_reset(24'h030000, 0);
        cyc(0, 0);
        chk("ready_after_midframe_rst", u_if.s_ready, 1);
        repeat (40) cyc(0, 1);
        chk("relock_after_midframe_rst", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
